sram_burst_ctrl: RTL and testbench
==================================

Name: sram_burst_ctrl

Overview:
- Initiator-side controller for the 19-bit-address, 32-bit, byte-write-enable synchronous SRAM macro.
- Turns valid/ready burst requests from the bus-slave wrapper into SRAM pin sequences (CS, OE, WEB[3:0], A, DI).
- Returns read beats through a backpressured data channel. Absorbs the SRAM's one-cycle read latency with a 2-entry skid buffer.

Parameters:
ADDR_W, 19, SRAM word-address width
DATA_W, 32, data width (4 byte lanes)
LEN_W, 4, burst-length field width; beats = req_len+1 (1..16)

Ports:
clk  in  1  clock, also drives the SRAM CK
rst  in  1  synchronous active-high reset
req_valid  in  1  burst request valid
req_ready  out  1  request accepted when valid&&ready
req_write  in  1  1=write burst, 0=read burst
req_addr  in  ADDR_W  starting word address
req_len  in  LEN_W  beats minus one
req_wstrb  in  4  byte enables for the whole write burst (bit i = byte i)
wdata_valid  in  1  write beat valid
wdata_ready  out  1  write beat accepted
wdata  in  DATA_W  write beat data
wdata_last  in  1  sender marks final write beat
rdata_valid  out  1  read beat valid
rdata_ready  in  1  read beat consumed
rdata  out  DATA_W  read beat data
rdata_last  out  1  final read beat of burst
wr_done  out  1  one-cycle pulse after final write beat is issued
len_err  out  1  sticky: wdata_last disagreed with the beat counter
sram_cs  out  1  SRAM chip select, active high
sram_oe  out  1  SRAM output enable, active high
sram_web  out  4  SRAM byte write enables, active low
sram_a  out  ADDR_W  SRAM address
sram_di  out  DATA_W  SRAM write data
sram_do  in  DATA_W  SRAM read data, valid the cycle after a read issue

Behaviour:
- States: IDLE, WRITE, READ, RDRAIN.
- Reset (synchronous, rst high):
  - State goes to IDLE; skid buffer and in-flight flag are flushed.
  - Outputs: sram_cs=0, sram_oe=0, sram_web=4'hF, sram_a=0, sram_di=0, rdata_valid=0, rdata_last=0, wr_done=0, len_err=0.
  - req_ready and wdata_ready are forced to 0 while rst is high.
  - Reset mid-burst aborts with no further CS pulse. Remaining beats are not issued.
- IDLE:
  - req_ready=1.
  - On handshake, latch addr, len, wstrb and write flag into a beat counter cnt=req_len, then go to WRITE or READ.
  - No SRAM access is issued in the accept cycle.
- WRITE:
  - wdata_ready=1.
  - Each cycle with wdata_valid: sram_cs=1, sram_web=~wstrb, sram_a=cur_addr, sram_di=wdata (all combinational from the current beat).
  - Then cur_addr+1 and cnt-1.
  - Cycles without wdata_valid: sram_cs=0, sram_web=4'hF.
  - On the beat with cnt==0: go to IDLE and pulse wr_done in the next cycle.
  - If wdata_last != (cnt==0) on any accepted beat, set len_err. The burst still ends by counter.
  - wstrb=0 issues CS with WEB=4'hF (harmless read; result discarded).
- READ:
  - sram_oe=1, sram_web=4'hF.
  - Issue a beat (sram_cs=1, sram_a=cur_addr) only when buffer occupancy plus in-flight beats is less than 2.
  - One cycle after an issue, capture sram_do into the buffer, tagged last if it was the cnt==0 beat.
  - After the last beat is issued, go to RDRAIN.
- RDRAIN:
  - sram_oe=1, sram_cs=0.
  - When the tagged-last beat handshakes on rdata, go to IDLE.
- Read channel:
  - rdata_valid=1 whenever the buffer is non-empty. rdata and rdata_last come from the head entry.
  - Push and pop in the same cycle keep occupancy unchanged.
  - rdata stays stable while valid&&!ready.
  - At most 1 beat per cycle. With rdata_ready held high, throughput is 1 beat/cycle and first data appears 2 cycles after the request handshake.
- Address arithmetic: cur_addr increments modulo 2^ADDR_W, so 19'h7FFFF wraps to 0 within a burst.
- The SRAM is never selected in IDLE.

Test Plan:
- Single write then read: write addr 19'h00010, len 0, strb 4'hF, data 32'hAABBCCDD; then read same addr -> one CS pulse with web=4'h0; wr_done pulses once; rdata=32'hAABBCCDD with rdata_last=1.
- Partial strobe: over 32'hAABBCCDD, write strb 4'b0011 data 32'h11223344 -> sram_web=4'b1100; readback 32'hAABB3344.
- 4-beat read under backpressure: preload addr 0x20..0x23 with 1,2,3,4; hold rdata_ready low 5 cycles -> at most 2 CS pulses before stall; then beats 1,2,3,4 in order; rdata_last only on 4; no beat lost or duplicated.
- Address wrap: 3-beat write at 19'h7FFFE -> sram_a sequence 7FFFE, 7FFFF, 00000; readback matches.
- Reset mid-burst: 8-beat write, assert rst after beat 3 -> sram_cs=0 from the reset cycle; req_ready=1 the cycle after rst drops; only the first 3 words are modified.
- Length mismatch: len 3 with wdata_last asserted on beat 2 -> len_err=1 and sticky; 4 writes still issued; wr_done pulses once.

Source files
------------

// File: rtl/sram_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_burst_ctrl_if
//  Purpose  : Bundles every non-clock/reset signal of sram_burst_ctrl.
//             The bundle covers the burst request channel, the write-data
//             channel, the read-data channel, the status outputs and the
//             SRAM macro pins.
//  Modports : slave  - the controller (sram_burst_ctrl)
//             master - the bus-slave wrapper / SRAM side driving the controller
//  Signals  :
//    req_valid/req_ready/req_write/req_addr/req_len/req_wstrb  burst request
//    wdata_valid/wdata_ready/wdata/wdata_last                  write beats
//    rdata_valid/rdata_ready/rdata/rdata_last                  read beats
//    wr_done (pulse), len_err (sticky)                         status
//    sram_cs/sram_oe/sram_web/sram_a/sram_di (out), sram_do (in) SRAM pins
//  Revision : 1.0  initial release
// ============================================================================
interface sram_burst_ctrl_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [3:0]        req_wstrb;

  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              wdata_last;

  logic              rdata_valid;
  logic              rdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_last;

  logic              wr_done;
  logic              len_err;

  logic              sram_cs;
  logic              sram_oe;
  logic [3:0]        sram_web;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_di;
  logic [DATA_W-1:0] sram_do;

  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_wstrb,
    output req_ready,
    input  wdata_valid, wdata, wdata_last,
    output wdata_ready,
    output rdata_valid, rdata, rdata_last,
    input  rdata_ready,
    output wr_done, len_err,
    output sram_cs, sram_oe, sram_web, sram_a, sram_di,
    input  sram_do
  );

  modport master (
    output req_valid, req_write, req_addr, req_len, req_wstrb,
    input  req_ready,
    output wdata_valid, wdata, wdata_last,
    input  wdata_ready,
    input  rdata_valid, rdata, rdata_last,
    output rdata_ready,
    input  wr_done, len_err,
    input  sram_cs, sram_oe, sram_web, sram_a, sram_di,
    output sram_do
  );
endinterface
`default_nettype wire

// File: rtl/sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_burst_ctrl
//  Purpose  : Initiator-side burst controller for a synchronous, byte-write-
//             enable SRAM macro with one cycle of read latency. Accepts
//             valid/ready burst requests, drives the SRAM pins for each beat
//             and returns read beats through a 2-entry skid buffer.
//  Ports    :
//    clk  - clock (also the SRAM CK)
//    rst  - synchronous active-high reset
//    bus  - sram_burst_ctrl_if.slave: request, write-data, read-data,
//           status and SRAM pin groups
//  Revision : 1.0  initial release
// ============================================================================
module sram_burst_ctrl #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_burst_ctrl_if.slave       bus
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_WRITE  = 2'd1;
  localparam logic [1:0] c_READ   = 2'd2;
  localparam logic [1:0] c_RDRAIN = 2'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;          // address of the next beat
  logic [LEN_W-1:0]  r_cnt;           // beats remaining minus one
  logic [3:0]        r_wstrb;
  logic              r_wr_done;
  logic              r_len_err;

  // Read skid buffer: two entries, circular pointers plus occupancy count.
  logic [DATA_W-1:0] r_buf_data [2];
  logic [1:0]        r_buf_last;
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_occ;

  // A read was issued last cycle; its data is on sram_do this cycle.
  logic              r_inflight;
  logic              r_inflight_last;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic              w_last_beat;
  logic              w_wr_beat;
  logic              w_rd_issue;
  logic              w_push;
  logic              w_pop;
  logic [2:0]        w_pending;

  assign w_last_beat = (r_cnt == '0);
  assign w_wr_beat   = !rst && (r_state == c_WRITE) && bus.wdata_valid;
  assign w_push      = r_inflight;
  assign w_pop       = !rst && (r_occ != 2'd0) && bus.rdata_ready;

  // Slots committed at the end of this cycle: buffered beats plus the beat
  // landing from the SRAM, minus the one leaving on rdata. Crediting the
  // pop lets a continuously-ready consumer see one beat per cycle while the
  // buffer still can never hold more than two entries.
  assign w_pending   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_issue  = !rst && (r_state == c_READ) && (w_pending < 3'd2);

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.req_ready   = !rst && (r_state == c_IDLE);
  assign bus.wdata_ready = !rst && (r_state == c_WRITE);

  // SRAM pins follow the current beat combinationally, so a reset in the
  // middle of a burst drops CS in the very cycle rst is asserted.
  assign bus.sram_cs  = w_wr_beat || w_rd_issue;
  assign bus.sram_oe  = !rst && ((r_state == c_READ) || (r_state == c_RDRAIN));
  assign bus.sram_web = w_wr_beat ? ~r_wstrb : 4'hF;
  assign bus.sram_a   = rst ? '0 : r_addr;
  assign bus.sram_di  = w_wr_beat ? bus.wdata : '0;

  assign bus.rdata_valid = !rst && (r_occ != 2'd0);
  assign bus.rdata       = r_buf_data[r_rd_ptr];
  assign bus.rdata_last  = !rst && (r_occ != 2'd0) && r_buf_last[r_rd_ptr];

  assign bus.wr_done = !rst && r_wr_done;
  assign bus.len_err = !rst && r_len_err;

  // --------------------------------------------------------------------------
  // FSM, address/beat counter, status flags and buffer bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= c_IDLE;
      r_addr          <= '0;
      r_cnt           <= '0;
      r_wstrb         <= '0;
      r_wr_done       <= 1'b0;
      r_len_err       <= 1'b0;
      r_buf_last      <= 2'b00;
      r_rd_ptr        <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_occ           <= 2'd0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_wr_done  <= 1'b0;
      r_inflight <= w_rd_issue;
      if (w_rd_issue) begin
        r_inflight_last <= w_last_beat;
      end

      case (r_state)
        c_IDLE: begin
          if (bus.req_valid) begin
            r_addr  <= bus.req_addr;
            r_cnt   <= bus.req_len;
            r_wstrb <= bus.req_wstrb;
            r_state <= bus.req_write ? c_WRITE : c_READ;
          end
        end

        c_WRITE: begin
          if (bus.wdata_valid) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_cnt  <= r_cnt - LEN_W'(1);
            // The sender's framing is only reported; the counter decides
            // where the burst ends.
            if (bus.wdata_last != w_last_beat) begin
              r_len_err <= 1'b1;
            end
            if (w_last_beat) begin
              r_state   <= c_IDLE;
              r_wr_done <= 1'b1;
            end
          end
        end

        c_READ: begin
          if (w_rd_issue) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_cnt  <= r_cnt - LEN_W'(1);
            if (w_last_beat) begin
              r_state <= c_RDRAIN;
            end
          end
        end

        c_RDRAIN: begin
          if (w_pop && r_buf_last[r_rd_ptr]) begin
            r_state <= c_IDLE;
          end
        end

        default: r_state <= c_IDLE;
      endcase

      if (w_push) begin
        r_buf_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Buffer payload needs no reset: an entry is only visible once occupancy
  // says it was written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_data[r_wr_ptr] <= bus.sram_do;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_burst_ctrl
//  Purpose  : Self-checking bench for sram_burst_ctrl. Contains a behavioural
//             byte-write SRAM with one cycle of read latency and a reference
//             memory image; read expectations are queued when a read burst
//             is requested and compared as beats leave the controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_burst_ctrl;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_burst_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  sram_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // --------------------------------------------------------------------------
  // Behavioural SRAM: byte writes, registered read data
  // --------------------------------------------------------------------------
  logic [31:0] mem [0:(1<<ADDR_W)-1];

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    bus.sram_do = 32'h0;
  end

  always @(posedge clk) begin
    if (bus.sram_cs) begin
      bus.sram_do <= mem[bus.sram_a];
      for (int b = 0; b < 4; b++) begin
        if (!bus.sram_web[b]) mem[bus.sram_a][8*b +: 8] <= bus.sram_di[8*b +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t             sb[$];
  logic [31:0]       ref_mem [int];
  logic [ADDR_W-1:0] wa_log[$];
  logic [3:0]        web_log[$];
  int                cs_cnt     = 0;
  int                wrdone_cnt = 0;
  int                rx_cnt     = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_get(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction

  task automatic ref_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = ref_get(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    ref_mem[int'(a)] = v;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (bus.sram_cs) begin
        cs_cnt++;
        if (bus.sram_web != 4'hF) begin
          wa_log.push_back(bus.sram_a);
          web_log.push_back(bus.sram_web);
        end
      end
      if (bus.wr_done) wrdone_cnt++;
      if (bus.rdata_valid && bus.rdata_ready) begin
        rx_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_rdata_beat", {32'h0, bus.rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("rdata", {32'h0, bus.rdata}, {32'h0, e.d});
          chk("rdata_last", {63'h0, bus.rdata_last}, {63'h0, e.l});
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [LEN_W-1:0] l, input logic [3:0] s);
    int t = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_len   = l;
    bus.req_wstrb = s;
    @(negedge clk);
    while (!bus.req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("req_accept", {63'h0, bus.req_ready}, 64'h1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    int t = 0;
    bus.wdata_valid = 1'b1;
    bus.wdata       = d;
    bus.wdata_last  = last;
    @(negedge clk);
    while (!bus.wdata_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("wdata_accept", {63'h0, bus.wdata_ready}, 64'h1);
    @(posedge clk);
    #1;
    bus.wdata_valid = 1'b0;
    bus.wdata_last  = 1'b0;
  endtask

  task automatic write_burst(input logic [ADDR_W-1:0] a, input int n, input logic [31:0] base,
                             input logic [3:0] s, input int last_at);
    send_req(1'b1, a, LEN_W'(n - 1), s);
    for (int i = 0; i < n; i++) begin
      send_beat(base + 32'(i), i == last_at);
      ref_wr(a + ADDR_W'(i), base + 32'(i), s);
    end
    repeat (2) tick();
  endtask

  task automatic queue_read(input logic [ADDR_W-1:0] a, input int n);
    for (int i = 0; i < n; i++) sb.push_back('{d: ref_get(a + ADDR_W'(i)), l: (i == n - 1)});
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    chk(tag, 64'(sb.size()), 64'h0);
    repeat (3) tick();
    chk("no_extra_beat", {63'h0, bus.rdata_valid}, 64'h0);
  endtask

  task automatic read_burst(input logic [ADDR_W-1:0] a, input int n);
    queue_read(a, n);
    send_req(1'b0, a, LEN_W'(n - 1), 4'h0);
    wait_drain("read_drain");
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.req_len     = '0;
    bus.req_wstrb   = 4'h0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    bus.wdata_last  = 1'b0;
    bus.rdata_ready = 1'b1;

    // Reset values
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req_ready", {63'h0, bus.req_ready}, 64'h0);
    chk("rst_cs", {63'h0, bus.sram_cs}, 64'h0);
    chk("rst_web", {60'h0, bus.sram_web}, 64'hF);
    chk("rst_rdata_valid", {63'h0, bus.rdata_valid}, 64'h0);
    chk("rst_len_err", {63'h0, bus.len_err}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", {63'h0, bus.req_ready}, 64'h1);
    chk("idle_cs", {63'h0, bus.sram_cs}, 64'h0);
    tick();

    // Single write then read
    wa_log.delete(); web_log.delete(); wrdone_cnt = 0;
    write_burst(19'h00010, 1, 32'hAABBCCDD, 4'hF, 0);
    chk("w1_cs_count", 64'(wa_log.size()), 64'h1);
    chk("w1_web", {60'h0, web_log[0]}, 64'h0);
    chk("w1_addr", {45'h0, wa_log[0]}, 64'h10);
    chk("w1_wr_done", 64'(wrdone_cnt), 64'h1);
    read_burst(19'h00010, 1);

    // Partial strobe write over the same word
    wa_log.delete(); web_log.delete();
    write_burst(19'h00010, 1, 32'h11223344, 4'b0011, 0);
    chk("ps_web", {60'h0, web_log[0]}, 64'hC);
    read_burst(19'h00010, 1);

    // 4-beat read under backpressure
    write_burst(19'h00020, 4, 32'h1, 4'hF, 3);
    bus.rdata_ready = 1'b0;
    queue_read(19'h00020, 4);
    rx_cnt = 0;
    cs_cnt = 0;
    send_req(1'b0, 19'h00020, 4'd3, 4'h0);
    repeat (5) tick();
    chk("bp_cs_le2", {63'h0, (cs_cnt <= 2)}, 64'h1);
    chk("bp_valid", {63'h0, bus.rdata_valid}, 64'h1);
    chk("bp_head", {32'h0, bus.rdata}, 64'h1);
    chk("bp_oe", {63'h0, bus.sram_oe}, 64'h1);
    bus.rdata_ready = 1'b1;
    wait_drain("bp_drain");
    chk("bp_beats", 64'(rx_cnt), 64'h4);
    chk("bp_total_cs", 64'(cs_cnt), 64'h4);

    // Address wrap inside a burst
    wa_log.delete(); web_log.delete();
    write_burst(19'h7FFFE, 3, 32'hC0DE0000, 4'hF, 2);
    chk("wrap_n", 64'(wa_log.size()), 64'h3);
    chk("wrap_a0", {45'h0, wa_log[0]}, 64'h7FFFE);
    chk("wrap_a1", {45'h0, wa_log[1]}, 64'h7FFFF);
    chk("wrap_a2", {45'h0, wa_log[2]}, 64'h00000);
    read_burst(19'h7FFFE, 3);

    // Reset in the middle of an 8-beat write
    write_burst(19'h00040, 8, 32'hF0, 4'hF, 7);
    wrdone_cnt = 0;
    send_req(1'b1, 19'h00040, 4'd7, 4'hF);
    for (int i = 0; i < 3; i++) begin
      send_beat(32'h500 + 32'(i), 1'b0);
      ref_wr(19'h00040 + ADDR_W'(i), 32'h500 + 32'(i), 4'hF);
    end
    bus.wdata_valid = 1'b1;
    bus.wdata       = 32'hDEAD_BEEF;
    rst             = 1'b1;
    @(negedge clk);
    chk("mid_rst_cs", {63'h0, bus.sram_cs}, 64'h0);
    chk("mid_rst_wdata_ready", {63'h0, bus.wdata_ready}, 64'h0);
    chk("mid_rst_req_ready", {63'h0, bus.req_ready}, 64'h0);
    @(posedge clk);
    #1;
    rst             = 1'b0;
    bus.wdata_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {63'h0, bus.req_ready}, 64'h1);
    tick();
    chk("rst_no_wr_done", 64'(wrdone_cnt), 64'h0);
    read_burst(19'h00040, 8);

    // Length mismatch: wdata_last on beat 2 of a 4-beat burst
    chk("len_err_clear", {63'h0, bus.len_err}, 64'h0);
    wa_log.delete(); web_log.delete(); wrdone_cnt = 0;
    write_burst(19'h00060, 4, 32'h600, 4'hF, 1);
    chk("len_err_set", {63'h0, bus.len_err}, 64'h1);
    chk("len_err_writes", 64'(wa_log.size()), 64'h4);
    chk("len_err_wr_done", 64'(wrdone_cnt), 64'h1);
    read_burst(19'h00060, 4);
    chk("len_err_sticky", {63'h0, bus.len_err}, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
